uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared FSM encoding and oversampling constants for uart_rx
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int END_TICK   = 15;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver: free-running tick generator plus frame FSM
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = uart_rx_pkg::OVERSAMPLE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] baud_division,
    input  logic        rx,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        frame_error
);

    localparam int               TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] MID      = TICK_W'(MID_TICK);
    localparam logic [TICK_W-1:0] LAST     = TICK_W'(END_TICK);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    logic [31:0]          cnt_q;
    logic                 tick;
    rx_state_e            state_q;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 armed_q;
    logic [7:0]           data_q;
    logic                 data_valid_q;
    logic                 frame_error_q;

    uart_rx_sync u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    // >= rather than == so a mid-frame shrink of baud_division wraps at once instead of after 2^32 clocks
    assign tick = (cnt_q >= baud_division);

    always_ff @(posedge clk) begin
        if (rst || tick) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= '0;
            armed_q       <= 1'b0;
            data_q        <= 8'd0;
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            data_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    IDLE: begin
                        // a start edge only counts once the line has been seen high since the last frame
                        if (rx_s) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            state_q    <= START;
                            tick_cnt_q <= '0;
                            armed_q    <= 1'b0;
                        end
                    end
                    START: begin
                        if (tick_cnt_q == MID) begin
                            if (!rx_s) begin
                                state_q    <= DATA;
                                tick_cnt_q <= '0;
                                bit_idx_q  <= 3'd0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                    DATA: begin
                        if (tick_cnt_q == LAST) begin
                            shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
                            tick_cnt_q <= '0;
                            if (bit_idx_q == LAST_BIT) begin
                                state_q <= STOP;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt_q == LAST) begin
                            data_q        <= 8'(shift_q);
                            data_valid_q  <= rx_s;
                            frame_error_q <= ~rx_s;
                            state_q       <= IDLE;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign frame_error = frame_error_q;

endmodule
